// File: rtl/multi_seq_acc_if.sv
// Operand/result handshake bundle for multi_seq_acc.
// master: operand scheduler side; slave: the multiplier.
interface multi_seq_acc_if #(
    parameter int RADIX = 78
);
    logic               in_valid;
    logic               in_ready;
    logic [RADIX-1:0]   a;
    logic [RADIX-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*RADIX-1:0] prod;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/multi_seq_acc.sv
// Time-multiplexed limb multiplier: one limb product per cycle, shift-accumulated.
// Optional partial-product tap outputs when MULTI_PP_TAP_EN is defined.
module multi_seq_acc #(
    parameter int RADIX   = 78,
    parameter int A_LIMB  = 26,
    parameter int B_LIMB  = 17,
    parameter int DSP_LAT = 3,
    localparam int NA = (RADIX + A_LIMB - 1) / A_LIMB,
    localparam int NB = (RADIX + B_LIMB - 1) / B_LIMB,
    localparam int NK = NA * NB,
    localparam int KW = (NK > 1) ? $clog2(NK) : 1,
    localparam int PW = A_LIMB + B_LIMB
) (
    input logic clk,
    input logic rst,
    multi_seq_acc_if.slave bus
`ifdef MULTI_PP_TAP_EN
    ,
    output logic          pp_valid,
    output logic [KW-1:0] pp_idx,
    output logic [PW-1:0] pp_data
`endif
);
    localparam int AW = NA * A_LIMB;
    localparam int BW = NB * B_LIMB;
    localparam int RW = 2 * RADIX;
    localparam int IW = (NA > 1) ? $clog2(NA) : 1;
    localparam int JW = (NB > 1) ? $clog2(NB) : 1;
    localparam int L  = DSP_LAT - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [AW-1:0] a_q;
    logic [BW-1:0] b_q;
    logic [KW-1:0] k;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [RW-1:0] acc;
    logic          ret_last;

    logic [DSP_LAT-1:0] pv;
    logic [PW-1:0]      pd [DSP_LAT];
    logic [IW-1:0]      pi [DSP_LAT];
    logic [JW-1:0]      pj [DSP_LAT];
`ifdef MULTI_PP_TAP_EN
    logic [KW-1:0]      pk [DSP_LAT];
`endif

    logic              accept;
    logic              issue;
    logic              retire;
    logic              k_last;
    logic [A_LIMB-1:0] a_limb;
    logic [B_LIMB-1:0] b_limb;
    logic [PW-1:0]     mul;
    logic [RW-1:0]     addend;

    assign accept = bus.in_valid && (state == IDLE);
    assign issue  = (state == ISSUE);
    assign retire = pv[L];
    assign k_last = (k == KW'(NK - 1));

    // Padded limbs read back as zero because a_q/b_q are zero-extended.
    assign a_limb = a_q[int'(i) * A_LIMB +: A_LIMB];
    assign b_limb = b_q[int'(j) * B_LIMB +: B_LIMB];
    assign mul    = PW'(a_limb) * PW'(b_limb);
    assign addend = RW'(pd[L]) << (int'(pi[L]) * A_LIMB + int'(pj[L]) * B_LIMB);

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.prod      = acc;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nx = ISSUE;
            ISSUE:   if (k_last)        state_nx = DRAIN;
            DRAIN:   if (ret_last)      state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            i        <= '0;
            j        <= '0;
            acc      <= '0;
            pv       <= '0;
            ret_last <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state    <= state_nx;
            pv[0]    <= issue;
            for (int s = 1; s < DSP_LAT; s++) pv[s] <= pv[s-1];
            // Tags retire in issue order, so the last tag marks completion.
            ret_last <= retire && (pi[L] == IW'(NA - 1)) && (pj[L] == JW'(NB - 1));
            if (accept) begin
                a_q <= AW'(bus.a);
                b_q <= BW'(bus.b);
                acc <= '0;
                k   <= '0;
                i   <= '0;
                j   <= '0;
            end else begin
                if (retire) acc <= acc + addend;
                if (issue) begin
                    k <= k_last ? '0 : k + KW'(1);
                    if (j == JW'(NB - 1)) begin
                        j <= '0;
                        i <= (i == IW'(NA - 1)) ? '0 : i + IW'(1);
                    end else begin
                        j <= j + JW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        pd[0] <= mul;
        pi[0] <= i;
        pj[0] <= j;
`ifdef MULTI_PP_TAP_EN
        pk[0] <= k;
`endif
        for (int s = 1; s < DSP_LAT; s++) begin
            pd[s] <= pd[s-1];
            pi[s] <= pi[s-1];
            pj[s] <= pj[s-1];
`ifdef MULTI_PP_TAP_EN
            pk[s] <= pk[s-1];
`endif
        end
    end

`ifdef MULTI_PP_TAP_EN
    assign pp_valid = pv[L];
    assign pp_idx   = pk[L];
    assign pp_data  = pd[L];
`endif
endmodule
